// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core boot path: data width, the
// canonical NOP encoding and the instruction-memory loader state type.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // HDR  : collecting the 4-byte little-endian word-count header
   // LOAD : collecting program words and writing them to IMEM
   // RUN  : program loaded, core released from reset
   // ERR  : header asked for more words than IMEM holds (terminal)
   typedef enum logic [1:0] {
      LDR_HDR  = 2'd0,
      LDR_LOAD = 2'd1,
      LDR_RUN  = 2'd2,
      LDR_ERR  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port.
// The array has no reset so its contents survive a loader reset.
module imem_ram
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [XLEN-1:0]   rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [XLEN-1:0] mem [DEPTH];

   // Write on the rising edge; a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Combinational read.
   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM loader. Receives a byte stream (4-byte little-endian word
// count N, then N little-endian program words), writes the words into IMEM
// and holds the core in reset until the whole program is in place. After
// that it serves instrF combinationally from pcF.
//
// Byte handshake: a byte transfers on every rising edge where
// byte_valid && byte_ready. byte_ready is high exactly in HDR and LOAD and
// depends only on state, never on byte_valid, so a transfer costs no bubble.
// Nothing advances (lane counter, partial word, state) without a transfer.
module imem_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            byte_valid,
   input  logic [7:0]      byte_data,
   output logic            byte_ready,
   input  logic [XLEN-1:0] pcF,
   output logic [XLEN-1:0] instrF,
   output logic            core_rst_n,
   output logic            load_done,
   output logic            load_err
);

   // Depth kept 33 bits wide so the header check uses the full 32-bit N
   // and N == depth is still accepted.
   localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

   loader_state_t     state;
   logic [1:0]        lane;
   logic [23:0]       part;
   logic [ADDR_W-1:0] word_cnt;
   logic [31:0]       len_q;

   logic              accept;
   logic              word_end;
   logic [31:0]       word;
   logic              last_word;
   logic              ram_we;

   assign byte_ready = (state == LDR_HDR) || (state == LDR_LOAD);
   assign accept     = byte_valid && byte_ready;
   assign word_end   = accept && (lane == 2'd3);

   // Lanes 0..2 sit in part[23:0] (lane 0 lowest); lane 3 is the live byte.
   assign word      = {byte_data, part};
   assign last_word = ({{(32-ADDR_W){1'b0}}, word_cnt} == (len_q - 32'd1));
   assign ram_we    = word_end && (state == LDR_LOAD);

   // Loader FSM, byte assembly, counters and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LDR_HDR;
         lane       <= 2'd0;
         part       <= 24'd0;
         word_cnt   <= '0;
         len_q      <= 32'd0;
         core_rst_n <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         // Release the core one cycle after RUN is entered, so its first
         // fetch sees the final word already written.
         core_rst_n <= (state == LDR_RUN);

         if (accept) begin
            lane <= lane + 2'd1;
            part <= {byte_data, part[23:8]};
         end

         case (state)
            LDR_HDR: begin
               if (word_end) begin
                  len_q <= word;
                  if (word == 32'd0) begin
                     state     <= LDR_RUN;
                     load_done <= 1'b1;
                  end else if ({1'b0, word} > DEPTH) begin
                     state    <= LDR_ERR;
                     load_err <= 1'b1;
                  end else begin
                     state <= LDR_LOAD;
                  end
               end
            end
            LDR_LOAD: begin
               if (word_end) begin
                  word_cnt <= word_cnt + 1'b1;
                  if (last_word) begin
                     state     <= LDR_RUN;
                     load_done <= 1'b1;
                  end
               end
            end
            default: begin
               // RUN and ERR only leave through rst_n.
            end
         endcase
      end
   end

   // pcF[1:0] and the bits above the IMEM index do not take part in the
   // lookup; addresses wrap modulo the IMEM depth.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pcF[XLEN-1:ADDR_W+2], pcF[1:0]};

   imem_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (word_cnt),
      .wdata (word),
      .raddr (pcF[ADDR_W+1:2]),
      .rdata (instrF)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed boot scenarios plus randomized loads with
// random valid gaps, checked against a word-level model of IMEM contents.
module tb_imem_loader;
   import riscv_pkg::*;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1 << ADDR_W;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic [31:0] pcF;
   logic [31:0] instrF;
   logic        core_rst_n;
   logic        load_done;
   logic        load_err;

   always #5 clk = ~clk;

   imem_loader #(
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .pcF        (pcF),
      .instrF     (instrF),
      .core_rst_n (core_rst_n),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   // ---------------- reference model ----------------
   // IMEM image as the program stream dictates it; only words known to
   // have been written are compared.
   logic [31:0] ref_mem   [DEPTH];
   bit          ref_known [DEPTH];
   logic [31:0] exp_q [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Status packed as {byte_ready, core_rst_n, load_done, load_err}.
   task automatic check_status(input string tag, input bit r, input bit c, input bit d, input bit e);
      check(tag, {28'd0, byte_ready, core_rst_n, load_done, load_err},
            {28'd0, r, c, d, e});
   endtask

   task automatic model_write(input int idx, input logic [31:0] w);
      ref_mem[idx]   = w;
      ref_known[idx] = 1'b1;
   endtask

   // Read every known word back, with random junk in the ignored low bits
   // and in the upper bits that must wrap away.
   task automatic check_mem(input string tag);
      logic [31:0] a;
      for (int i = 0; i < DEPTH; i++) begin
         if (ref_known[i]) begin
            a       = $urandom;
            a[11:2] = i[9:0];
            pcF     = a;
            #1;
            check($sformatf("%s_mem%0d", tag, i), instrF, ref_mem[i]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      byte_valid = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int n;
      n = gaps ? $urandom_range(0, 3) : 0;
      repeat (n) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
   endtask

   // Full program: header N, then the words in exp_q; model updated per word.
   task automatic send_program(input bit gaps);
      int n;
      n = exp_q.size();
      send_word(32'(n), gaps);
      for (int i = 0; i < n; i++) begin
         send_word(exp_q[i], gaps);
         model_write(i, exp_q[i]);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] w1_old;
      rst_n      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      pcF        = 32'd0;
      for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

      do_reset();
      check_status("reset", 1, 0, 0, 0);

      // Normal load, back-to-back bytes.
      exp_q = '{32'h0010_0093, 32'h0020_0113};
      send_program(1'b0);
      check_status("normal_done_edge", 0, 0, 1, 0);
      @(posedge clk);
      #1;
      check_status("normal_release", 0, 1, 1, 0);
      pcF = 32'h0000_0004; #1;
      check("normal_pc4", instrF, 32'h0020_0113);
      pcF = 32'h0000_0000; #1;
      check("normal_pc0", instrF, 32'h0010_0093);
      pcF = 32'h0000_1004; #1;
      check("wrap_1004", instrF, 32'h0020_0113);
      pcF = 32'h0000_0006; #1;
      check("wrap_0006", instrF, 32'h0020_0113);
      // Asynchronous reset from RUN, sampled before the next edge.
      rst_n = 1'b0;
      #1;
      check_status("async_reset", 1, 0, 0, 0);

      // Same load with random valid gaps.
      do_reset();
      send_word(32'd2, 1'b1);
      check_status("gap_hdr", 1, 0, 0, 0);
      send_word(32'h0010_0093, 1'b1);
      check_status("gap_mid", 1, 0, 0, 0);
      send_word(32'h0020_0113, 1'b1);
      check_status("gap_done", 0, 0, 1, 0);
      check_mem("gap");

      // Randomized programs.
      for (int it = 0; it < 6; it++) begin
         int n;
         do_reset();
         n = $urandom_range(1, 12);
         exp_q.delete();
         for (int i = 0; i < n; i++) exp_q.push_back($urandom);
         send_program(it[0]);
         check_status($sformatf("rand%0d_done", it), 0, 0, 1, 0);
         @(posedge clk);
         #1;
         check_status($sformatf("rand%0d_release", it), 0, 1, 1, 0);
         check_mem($sformatf("rand%0d", it));
      end

      // Zero length: straight to RUN, further bytes ignored.
      do_reset();
      send_word(32'd0, 1'b0);
      check_status("zero_run", 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
      check_status("zero_ignore", 0, 1, 1, 0);
      check_mem("zero");

      // Overflow: N = depth + 1 goes to ERR and stays there.
      do_reset();
      send_word(32'd1025, 1'b0);
      check_status("ovf_err", 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
      check_status("ovf_hold", 0, 0, 0, 1);
      check_mem("ovf");

      // Largest legal program: N = depth fills the whole IMEM.
      do_reset();
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back($urandom);
      send_word(32'd1024, 1'b0);
      check_status("max_load", 1, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         send_word(exp_q[i], 1'b0);
         model_write(i, exp_q[i]);
      end
      check_status("max_done", 0, 0, 1, 0);
      check_mem("max");

      // Reset mid-load, mid-word, then reload a 1-word program.
      do_reset();
      exp_q = '{$urandom, $urandom, $urandom};
      send_word(32'd3, 1'b0);
      send_word(exp_q[0], 1'b0); model_write(0, exp_q[0]);
      send_word(exp_q[1], 1'b0); model_write(1, exp_q[1]);
      w1_old = exp_q[1];
      send_byte(exp_q[2][7:0], 1'b0);
      send_byte(exp_q[2][15:8], 1'b0);
      do_reset();
      check_status("midrst_reset", 1, 0, 0, 0);
      exp_q = '{$urandom};
      send_program(1'b1);
      check_status("midrst_done", 0, 0, 1, 0);
      @(posedge clk);
      #1;
      check_status("midrst_release", 0, 1, 1, 0);
      pcF = 32'h0000_0004; #1;
      check("midrst_keep1", instrF, w1_old);
      check_mem("midrst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
